fifo_burst_reader: RTL and testbench

Parametrised read-side controller for a dual-clock FIFO, operated in the FIFO's read clock domain. It watches the FIFO fill level and starts a read burst when the level reaches a threshold or the FIFO reports full. It then issues `rdreq` either until the FIFO is empty (drain mode) or for a fixed word count (burst mode). It honours a downstream `ready` stall, reports burst completion and read count, and flags underruns.

---
 rtl/fifo_burst_reader.sv | 92 +++++++++
 tb/tb_fifo_burst_reader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - read-side burst controller for a dual-clock FIFO
// Starts a burst on fill threshold or full, reads to empty or for BURST_LEN words.
module fifo_burst_reader #(
  parameter int USEDW_W   = 8,
  parameter int THRESH    = 128,
  parameter int BURST_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic               ready,
  input  logic               clr_err,
  input  logic [USEDW_W-1:0] rdusedw,
  input  logic               rdfull,
  input  logic               rdempty,
  output logic               rdreq,
  output logic               busy,
  output logic               burst_done,
  output logic [CNT_W-1:0]   rd_count,
  output logic               underrun
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

  localparam logic [USEDW_W-1:0] THRESH_W = USEDW_W'(THRESH);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  state_t           r_state;
  state_t           w_next;
  logic             r_mode_q;
  logic             r_busy;
  logic             r_burst_done;
  logic             r_underrun;
  logic [CNT_W-1:0] r_rd_count;
  logic             w_start;
  logic             w_rdreq;
  logic             w_last;
  logic             w_set_err;

  // rdfull covers the case where rdusedw has wrapped to 0 on a full FIFO
  assign w_start   = enable && (rdfull || (rdusedw >= THRESH_W));
  assign w_rdreq   = (r_state == S_READ) && ready && !rdempty;
  assign w_last    = w_rdreq && (r_rd_count == LAST_CNT);
  assign w_set_err = (r_state == S_READ) && r_mode_q && rdempty;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_READ;
      S_READ:  if (r_mode_q ? w_last : rdempty) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mode_q     <= 1'b0;
      r_busy       <= 1'b0;
      r_burst_done <= 1'b0;
      r_rd_count   <= '0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_busy       <= (w_next != S_IDLE);
      r_burst_done <= (w_next == S_DONE);
      if ((r_state == S_IDLE) && w_start) begin
        r_mode_q   <= mode;
        r_rd_count <= '0;
      end else if (w_rdreq && (r_rd_count != CNT_MAX)) begin
        r_rd_count <= r_rd_count + CNT_W'(1);
      end
      // a new underrun outranks a simultaneous clear
      if (w_set_err) begin
        r_underrun <= 1'b1;
      end else if (clr_err) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign rdreq      = w_rdreq;
  assign busy       = r_busy;
  assign burst_done = r_burst_done;
  assign rd_count   = r_rd_count;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader
// FIFO occupancy model plus burst-level reference, directed scenarios then random traffic.
module tb_fifo_burst_reader;

  localparam int USEDW_W   = 5;
  localparam int THRESH    = 4;
  localparam int BURST_LEN = 8;
  localparam int CNT_W     = 4;
  localparam int DEPTH     = 32;
  localparam int CMAX      = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, enable, mode, ready, clr_err;
  logic               rdfull, rdempty, full_ovr;
  logic [USEDW_W-1:0] rdusedw;
  logic               rdreq, busy, burst_done, underrun;
  logic [CNT_W-1:0]   rd_count;
  int                 lvl;

  always_comb begin
    rdusedw = USEDW_W'(lvl);
    rdfull  = (lvl == DEPTH) || full_ovr;
    rdempty = (lvl == 0);
  end

  fifo_burst_reader #(
    .USEDW_W(USEDW_W), .THRESH(THRESH), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .ready(ready),
    .clr_err(clr_err), .rdusedw(rdusedw), .rdfull(rdfull), .rdempty(rdempty),
    .rdreq(rdreq), .busy(busy), .burst_done(burst_done), .rd_count(rd_count),
    .underrun(underrun)
  );

  // reference: is a burst reading, is its finishing pulse due, words counted, latched mode, error
  bit m_reading, m_finishing, m_mode, m_err;
  int m_count;
  bit e_rd;
  int n_checks, n_fail, done_cnt, rd_cnt, cyc, first_rd, last_rd;

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  bit exp_rd, set_err, end_b;
  always @(negedge clk) begin
    exp_rd = m_reading && ready && !rdempty;
    cmp("rdreq", int'(rdreq), int'(exp_rd));
    cmp("busy", int'(busy), int'(m_reading || m_finishing));
    cmp("burst_done", int'(burst_done), int'(m_finishing));
    cmp("rd_count", int'(rd_count), m_count);
    cmp("underrun", int'(underrun), int'(m_err));
    if (rdreq) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (burst_done) done_cnt++;
    e_rd = exp_rd;
    if (rst) begin
      m_reading = 0; m_finishing = 0; m_mode = 0; m_err = 0; m_count = 0;
    end else begin
      set_err = m_reading && m_mode && rdempty;
      if (m_finishing) begin
        m_finishing = 0;
      end else if (m_reading) begin
        end_b = m_mode ? (exp_rd && m_count == BURST_LEN - 1) : rdempty;
        if (exp_rd && m_count < CMAX) m_count++;
        if (end_b) begin
          m_reading = 0;
          m_finishing = 1;
        end
      end else if (enable && (rdfull || int'(rdusedw) >= THRESH)) begin
        m_reading = 1;
        m_mode = mode;
        m_count = 0;
      end
      if (set_err) m_err = 1;
      else if (clr_err) m_err = 0;
    end
    cyc++;
  end

  task automatic tick(input int wr);
    @(posedge clk);
    #1;
    lvl = lvl - int'(e_rd);
    for (int i = 0; i < wr; i++) if (lvl < DEPTH) lvl++;
  endtask

  task automatic wait_done(input int target, input int bound, input string name);
    int k;
    k = 0;
    while (done_cnt < target && k < bound) begin
      tick(0);
      k++;
    end
    cmp(name, int'(done_cnt >= target), 1);
  endtask

  task automatic clear_stats();
    rd_cnt = 0;
    first_rd = -1;
    last_rd = -1;
  endtask

  int d0, k;
  initial begin
    rst = 1; enable = 0; mode = 0; ready = 0; clr_err = 0; full_ovr = 0; lvl = 0;
    n_checks = 0; n_fail = 0; done_cnt = 0; cyc = 0;
    clear_stats();
    repeat (3) tick(0);
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_rd_count", int'(rd_count), 0);
    cmp("reset_underrun", int'(underrun), 0);
    rst = 0;
    tick(0);

    // drain burst of 4 words written one per cycle
    enable = 1; mode = 0; ready = 1; clear_stats(); d0 = done_cnt;
    repeat (4) tick(1);
    wait_done(d0 + 1, 30, "drain_done");
    cmp("drain_reads", rd_cnt, 4);
    cmp("drain_rd_count", int'(rd_count), 4);
    cmp("drain_busy_after", int'(busy), 0);
    enable = 0;

    // fixed bursts from 20 words: 8 consecutive, then a second one
    tick(0); lvl = 20; mode = 1; clear_stats(); d0 = done_cnt; enable = 1;
    wait_done(d0 + 1, 30, "fixed_done1");
    cmp("fixed_reads", rd_cnt, 8);
    cmp("fixed_span", last_rd - first_rd + 1, 8);
    cmp("fixed_rd_count", int'(rd_count), 8);
    cmp("fixed_left", lvl, 12);
    wait_done(d0 + 2, 30, "fixed_done2");
    enable = 0;
    cmp("fixed2_reads", rd_cnt, 16);
    cmp("fixed2_left", lvl, 4);

    // ready toggling each cycle
    tick(0); lvl = 20; ready = 1; clear_stats(); d0 = done_cnt; enable = 1;
    tick(0); enable = 0; ready = 0;
    k = 0;
    while (done_cnt == d0 && k < 60) begin
      tick(0);
      ready = ~ready;
      k++;
    end
    cmp("toggle_done", int'(done_cnt > d0), 1);
    cmp("toggle_reads", rd_cnt, 8);
    cmp("toggle_span", last_rd - first_rd + 1, 15);
    cmp("toggle_underrun", int'(underrun), 0);
    cmp("toggle_rd_count", int'(rd_count), 8);

    // underrun: 5 words on a full-triggered fixed burst, then 3 more
    tick(0); lvl = 5; ready = 1; mode = 1; clear_stats(); d0 = done_cnt;
    full_ovr = 1; enable = 1;
    tick(0); full_ovr = 0; enable = 0;
    repeat (10) tick(0);
    cmp("ur_reads", rd_cnt, 5);
    cmp("ur_flag", int'(underrun), 1);
    cmp("ur_busy", int'(busy), 1);
    cmp("ur_rd_count", int'(rd_count), 5);
    repeat (3) tick(1);
    wait_done(d0 + 1, 20, "ur_done");
    cmp("ur_final_count", int'(rd_count), 8);
    cmp("ur_sticky", int'(underrun), 1);
    clr_err = 1; tick(0); clr_err = 0;
    cmp("ur_cleared", int'(underrun), 0);

    // enable low blocks full FIFO; mode flip mid-burst; count saturation
    tick(0); lvl = 32; mode = 0; clear_stats(); d0 = done_cnt;
    repeat (5) tick(0);
    cmp("dis_reads", rd_cnt, 0);
    cmp("dis_busy", int'(busy), 0);
    enable = 1; tick(0); enable = 0; mode = 1;
    wait_done(d0 + 1, 100, "sat_done");
    cmp("sat_reads", rd_cnt, 32);
    cmp("sat_rd_count", int'(rd_count), CMAX);
    cmp("sat_left", lvl, 0);

    // reset on the 3rd read of a fixed burst
    tick(0); lvl = 20; mode = 1; ready = 1; enable = 1;
    k = 0;
    while (!(m_reading && m_count == 2) && k < 50) begin
      tick(0);
      k++;
    end
    cmp("rst_reach", int'(m_reading && m_count == 2), 1);
    rst = 1; enable = 0; d0 = done_cnt;
    tick(0); rst = 0;
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_rd_count", int'(rd_count), 0);
    tick(0);
    cmp("rst_no_done", done_cnt, d0);
    clear_stats(); enable = 1;
    wait_done(d0 + 1, 30, "rst_next_done");
    enable = 0;
    cmp("rst_next_reads", rd_cnt, 8);
    cmp("rst_next_count", int'(rd_count), 8);

    // random traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      enable  = ($urandom % 4) != 0;
      mode    = $urandom % 2;
      ready   = ($urandom % 4) != 0;
      clr_err = ($urandom % 16) == 0;
      rst     = ($urandom % 256) == 0;
      tick($urandom % 3);
    end
    rst = 0;
    tick(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
